// File: rtl/calc_pkg.sv
// Shared constants for the BCD 7-segment scan driver: glyphs, blank/dash codes and scan states.
package calc_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low {g,f,e,d,c,b,a} glyphs; entry 0 is the rightmost element
    localparam logic [9:0][6:0] SEG_GLYPH = {
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    localparam logic ST_BLANK = 1'b0;
    localparam logic ST_DRIVE = 1'b1;

    typedef enum logic {
        S_BLANK = ST_BLANK,
        S_DRIVE = ST_DRIVE
    } scan_state_e;

endpackage

// File: rtl/bcd_seg7_scan_driver_if.sv
// Converter-to-display link: done level plus packed BCD digits.
interface bcd_seg7_scan_driver_if #(
    parameter int unsigned N_DIGITS = 4
);
    logic                    done_in;
    logic [4*N_DIGITS-1:0]   bcd_in;

    modport master (output done_in, output bcd_in);
    modport slave  (input  done_in, input  bcd_in);
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder; non-decimal nibbles give a dash.
module bcd_to_seg7
    import calc_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg_c
);

    // Glyph lookup, dash for 10..15
    always_comb begin
        o_seg_c = SEG_DASH;
        if (i_digit <= 4'd9) begin
            o_seg_c = SEG_GLYPH[i_digit];
        end
    end

endmodule

// File: rtl/bcd_seg7_scan_driver.sv
// Captures packed BCD on the rising edge of the converter done level and scans it onto a
// common-anode 7-segment display with a blanking slot between digits.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank zero digits above the highest non-zero one).
module bcd_seg7_scan_driver
    import calc_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_CYC   = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    bcd_seg7_scan_driver_if.slave   cvt,
    output logic [6:0]              seg_n,
    output logic [N_DIGITS-1:0]     an_n,
    output logic                    shown_vld
);

    localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned IDX_W   = $clog2(N_DIGITS);

    logic                       r_done_q;
    logic                       w_cap;
    logic [N_DIGITS-1:0][3:0]   r_shadow;
    logic                       r_shown;

    scan_state_e                r_state;
    scan_state_e                w_state_nxt;
    logic [CNT_W-1:0]           r_cnt;
    logic [CNT_W-1:0]           w_cnt_nxt;
    logic [IDX_W-1:0]           r_idx;
    logic [IDX_W-1:0]           w_idx_nxt;

    logic                       w_enter_drive;
    logic                       w_show;
    logic [6:0]                 w_dec_seg;
    logic [6:0]                 r_seg_n;
    logic [N_DIGITS-1:0]        r_an_n;

    assign w_cap = cvt.done_in & ~r_done_q;

    // Done edge detector and shadow capture; independent of the scan
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done_q <= 1'b0;
            r_shadow <= '0;
            r_shown  <= 1'b0;
        end else begin
            r_done_q <= cvt.done_in;
            if (w_cap) begin
                r_shadow <= cvt.bcd_in;
                r_shown  <= 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [N_DIGITS-1:0][3:0]   w_bcd;
    logic [N_DIGITS-1:0]        w_mask;
    logic                       w_seen;
    logic [N_DIGITS-1:0]        r_mask;

    assign w_bcd = cvt.bcd_in;

    // Significance mask: a digit is shown if it or any more significant digit is non-zero; digit 0 always
    always_comb begin
        w_mask = '0;
        w_seen = 1'b0;
        for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
            w_seen    = w_seen | (w_bcd[i] != 4'd0);
            w_mask[i] = w_seen | (i == 0);
        end
    end

    // Mask is captured together with the shadow so both always describe the same value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
        end else if (w_cap) begin
            r_mask <= w_mask;
        end
    end

    assign w_show = r_shown & r_mask[r_idx];
`else
    assign w_show = r_shown;
`endif

    // Scan state, slot counter and digit index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state: BLANK for BLANK_CYC cycles, DRIVE for REFRESH_DIV cycles, advance idx on leaving DRIVE
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        case (r_state)
            S_BLANK: begin
                if (r_cnt == CNT_W'(BLANK_CYC - 1)) begin
                    w_state_nxt = S_DRIVE;
                    w_cnt_nxt   = '0;
                end
            end
            S_DRIVE: begin
                if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                    w_state_nxt = S_BLANK;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_BLANK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_enter_drive = (r_state == S_BLANK) && (w_state_nxt == S_DRIVE);

    bcd_to_seg7 u_dec (
        .i_digit (r_shadow[r_idx]),
        .o_seg_c (w_dec_seg)
    );

    // Display registers: glyph latched at slot start so a mid-slot capture waits for the next slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_an_n  <= '1;
            r_seg_n <= SEG_BLANK;
        end else if (w_enter_drive) begin
            r_an_n  <= ~(N_DIGITS'(1) << r_idx);
            r_seg_n <= w_show ? w_dec_seg : SEG_BLANK;
        end else if (w_state_nxt == S_BLANK) begin
            r_an_n  <= '1;
            r_seg_n <= SEG_BLANK;
        end
    end

    assign seg_n     = r_seg_n;
    assign an_n      = r_an_n;
    assign shown_vld = r_shown;

endmodule

// File: tb/tb_bcd_seg7_scan_driver.sv
// Directed bench for bcd_seg7_scan_driver with N_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.
module tb_bcd_seg7_scan_driver;

    localparam int SLOT  = 10;
    localparam int FRAME = 40;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic       shown_vld;

    bcd_seg7_scan_driver_if #(.N_DIGITS(4)) cvt_if ();

    bcd_seg7_scan_driver #(
        .N_DIGITS    (4),
        .REFRESH_DIV (8),
        .BLANK_CYC   (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cvt       (cvt_if),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .shown_vld (shown_vld)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         k;
    logic [15:0] m_shadow;
    logic [3:0]  m_mask;
    logic        m_shown;
    logic        m_prev_done;
    logic [6:0]  slot_seg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s k=%0d: observed %h expected %h", tag, k, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic [3:0] digit_mask(input logic [15:0] v);
        logic [3:0] m;
        logic       seen;
        m    = 4'hF;
        seen = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 3; i >= 0; i--) begin
            seen = seen | (v[i*4 +: 4] != 4'd0);
            m[i] = seen | (i == 0);
        end
`endif
        return m;
    endfunction

    // Cycle k counts negedges since reset release; first DRIVE slot starts at k=2
    function automatic bit is_drive(input int kk);
        return (kk >= 2) && (((kk - 2) % SLOT) < 8);
    endfunction

    function automatic int slot_idx(input int kk);
        return ((kk - 2) / SLOT) % 4;
    endfunction

    function automatic logic [3:0] exp_an(input int kk);
        logic [3:0] one;
        one = 4'b0001;
        if (!is_drive(kk)) return 4'hF;
        return ~(one << slot_idx(kk));
    endfunction

    task automatic reset_model();
        k           = 0;
        m_shadow    = '0;
        m_mask      = '0;
        m_shown     = 1'b0;
        m_prev_done = 1'b0;
        slot_seg    = 7'h7F;
    endtask

    // One clock: update the expected display model, then check all outputs
    task automatic tick();
        int   nk;
        int   si;
        logic cap;
        nk  = k + 1;
        cap = cvt_if.done_in && !m_prev_done;
        if (nk >= 2 && ((nk - 2) % SLOT) == 0) begin
            si       = ((nk - 2) / SLOT) % 4;
            slot_seg = (m_shown && m_mask[si]) ? glyph(m_shadow[si*4 +: 4]) : 7'h7F;
        end
        m_prev_done = cvt_if.done_in;
        @(negedge clk);
        k = nk;
        if (cap) begin
            m_shadow = cvt_if.bcd_in;
            m_mask   = digit_mask(cvt_if.bcd_in);
            m_shown  = 1'b1;
        end
        chk("an_n", 32'(an_n), 32'(exp_an(k)));
        chk("seg_n", 32'(seg_n), is_drive(k) ? 32'(slot_seg) : 32'h7F);
        chk("shown_vld", 32'(shown_vld), 32'(m_shown));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset_n        = 1'b0;
        cvt_if.done_in = 1'b0;
        cvt_if.bcd_in  = 16'h0000;
        reset_model();
        repeat (2) @(negedge clk);
        chk("rst_an_n", 32'(an_n), 32'hF);
        chk("rst_seg_n", 32'(seg_n), 32'h7F);
        chk("rst_shown_vld", 32'(shown_vld), 32'h0);

        // Dark scan before any capture
        reset_n = 1'b1;
        run(FRAME + 2);

        // First capture, mid-slot
        cvt_if.bcd_in  = 16'h1234;
        cvt_if.done_in = 1'b1;
        run(FRAME + SLOT);

        // Held done level must not recapture
        cvt_if.bcd_in = 16'h5678;
        run(100);
        cvt_if.done_in = 1'b0;
        run(3);
        cvt_if.done_in = 1'b1;
        run(FRAME + SLOT);

        // Capture on the same edge that starts a DRIVE slot; dashes for 0xA and 0xF
        cvt_if.done_in = 1'b0;
        run(3);
        while (!((k + 1) >= 2 && ((k - 1) % SLOT) == 0)) tick();
        cvt_if.bcd_in  = 16'h0A0F;
        cvt_if.done_in = 1'b1;
        run(FRAME + SLOT);

        // All-zero and single-significant-digit values
        cvt_if.done_in = 1'b0;
        cvt_if.bcd_in  = 16'h0000;
        run(3);
        cvt_if.done_in = 1'b1;
        run(FRAME + SLOT);
        cvt_if.done_in = 1'b0;
        cvt_if.bcd_in  = 16'h0070;
        run(3);
        cvt_if.done_in = 1'b1;
        run(FRAME + SLOT);

        // Asynchronous reset in the middle of the idx2 DRIVE slot
        while (!(is_drive(k) && slot_idx(k) == 2 && ((k - 2) % SLOT) == 3)) tick();
        chk("pre_rst_an_n", 32'(an_n), 32'hB);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_an_n", 32'(an_n), 32'hF);
        chk("async_rst_seg_n", 32'(seg_n), 32'h7F);
        chk("async_rst_shown_vld", 32'(shown_vld), 32'h0);
        cvt_if.done_in = 1'b0;
        @(negedge clk);
        chk("held_rst_an_n", 32'(an_n), 32'hF);
        reset_n = 1'b1;
        reset_model();
        run(FRAME + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
